sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-port arbiter that shares the single SDRAM controller command interface (write_en, read_en, address, sdram_ready) between two requesters, e.g. a wishbone slave and a DMA/video master.
- Round-robin grant with a bounded hold time to prevent starvation.
- Waits for the controller to drain (ready high, write FIFO empty) before a new owner is switched in.
- Sits between the requesters and the controller in the same clk domain.

Parameters:
- MAX_HOLD, 1024: maximum ACTIVE cycles before the owner is preempted when the other port is waiting. 0 disables preemption.
- HOLD_WIDTH, 16: width of the hold counter. MAX_HOLD must fit in it.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 request; held high for the whole transfer
- p0_write  in  1  port 0 direction: 1 = write, 0 = read; stable while p0_req is high
- p0_address  in  22  port 0 start address; stable while p0_req is high
- p0_grant  out  1  port 0 owns the controller
- p0_done  out  1  one-cycle pulse when port 0 ownership ends
- p0_preempted  out  1  qualifies p0_done: ownership was ended by the hold timer
- p1_req, p1_write, p1_address, p1_grant, p1_done, p1_preempted: same as port 0, for port 1
- sdram_ready  in  1  controller idle/ready
- wr_fifo_empty  in  1  controller write FIFO empty
- write_en  out  1  write command to controller
- read_en  out  1  read command to controller
- address  out  22  address to controller
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, hold counter 0, last_owner=1 so port 0 wins the first tie. Asserting reset mid-transfer drops the enables and grants immediately.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - Leave only when sdram_ready=1 and at least one req is high.
  - Single requester is granted. If both request, grant the port that is not last_owner.
  - Next cycle: state ACTIVE, owner registered, pX_grant=1, address latched from the owner's pX_address, hold counter cleared.
- ACTIVE:
  - write_en = owner_req & owner_write; read_en = owner_req & !owner_write. Both registered, so 1-cycle latency from req.
  - address holds the latched value.
  - Hold counter increments each cycle and saturates at MAX_HOLD.
  - Owner req falls -> DRAIN (normal); enables 0 on the next cycle.
  - MAX_HOLD≠0, counter == MAX_HOLD-1 and other port's req=1 -> DRAIN with the preempt flag set; owner grant and enables drop on the next cycle.
  - Owner req falls in the same cycle the timer expires -> normal release; preempt flag clear.
- DRAIN:
  - Enables 0, owner grant 0.
  - Exit when sdram_ready=1 and, if the owner was writing, wr_fifo_empty=1.
  - On exit: pX_done pulses for one cycle, with pX_preempted = preempt flag in that cycle; last_owner <= owner; state IDLE.
  - A preempted port that keeps req high re-arbitrates normally and loses the tie to the waiting port.
- Minimum turnaround: 3 cycles between one grant and the next (ACTIVE -> DRAIN -> IDLE -> ACTIVE).
- A req that drops while ungranted is ignored; no latching of past requests.
- p0_grant and p1_grant are never both high.

Optional Feature:
- SDRAM_ARB_STATS_EN defined:
  - Adds outputs p0_grant_count[15:0], p1_grant_count[15:0] and preempt_count[15:0].
  - Grant counts increment on each grant; preempt_count increments on each preempted done. All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent; no other behaviour changes.

Test Plan:
- p0_req=1, write, addr 22'h000100, sdram_ready=1: p0_grant high 1 cycle later, write_en high the cycle after, address=22'h000100. Drop req: write_en 0; with wr_fifo_empty=0 for 5 cycles, p0_done pulses only after wr_fifo_empty=1.
- Both req in the same cycle after reset: port 0 granted first. After port 0 releases with p1_req still high, port 1 is granted; tie again -> port 0.
- MAX_HOLD=8, p0 holds req, p1_req raised: p0 preempted after 8 ACTIVE cycles; p0_done with p0_preempted=1; p1 granted; p0 re-granted after p1 releases.
- MAX_HOLD=8: owner req drops in the exact cycle the timer expires -> p0_preempted=0 on done.
- Both reqs high, sdram_ready=0: no grant until sdram_ready=1. Assert rst_n=0 during ACTIVE read: read_en, grants and busy go 0 asynchronously; first grant after reset is port 0.
- With SDRAM_ARB_STATS_EN defined: 3 grants to p1 and 1 preemption -> p1_grant_count=3, preempt_count=1.

Source files
------------

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Two-port round-robin arbiter with bounded hold time in front of a
//            single SDRAM controller command interface. Optional per-port grant
//            and preemption counters enabled by defining SDRAM_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module sdram_arbiter #(
  parameter int MAX_HOLD   = 1024,
  parameter int HOLD_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_write,
  input  logic [21:0] p0_address,
  output logic        p0_grant,
  output logic        p0_done,
  output logic        p0_preempted,
  input  logic        p1_req,
  input  logic        p1_write,
  input  logic [21:0] p1_address,
  output logic        p1_grant,
  output logic        p1_done,
  output logic        p1_preempted,
  input  logic        sdram_ready,
  input  logic        wr_fifo_empty,
  output logic        write_en,
  output logic        read_en,
  output logic [21:0] address,
  output logic        busy
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0] p0_grant_count,
  output logic [15:0] p1_grant_count,
  output logic [15:0] preempt_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX  = HOLD_WIDTH'(MAX_HOLD);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_WIDTH'(MAX_HOLD - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic                  preempt_q, preempt_d;
  logic                  wr_q, wr_d;
  logic [21:0]           addr_q, addr_d;
  logic [1:0]            grant_q, grant_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            pre_q, pre_d;

  logic owner_req, other_req, hold_hit, pick;

  assign owner_req = owner_q ? p1_req : p0_req;
  assign other_req = owner_q ? p0_req : p1_req;
  assign hold_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  // On a tie the port that did not own the controller last wins.
  assign pick      = (p0_req && p1_req) ? ~last_owner_q : p1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      hold_q       <= '0;
      preempt_q    <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      grant_q      <= '0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      done_q       <= '0;
      pre_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      preempt_q    <= preempt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      grant_q      <= grant_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      done_q       <= done_d;
      pre_q        <= pre_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    preempt_d    = preempt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    grant_d      = grant_q;
    wen_d        = 1'b0;
    ren_d        = 1'b0;
    done_d       = '0;
    pre_d        = '0;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (sdram_ready && (p0_req || p1_req)) begin
          state_d   = ST_ACTIVE;
          owner_d   = pick;
          grant_d   = pick ? 2'b10 : 2'b01;
          addr_d    = pick ? p1_address : p0_address;
          wr_d      = pick ? p1_write : p0_write;
          hold_d    = '0;
          preempt_d = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
        // A release in the expiry cycle counts as a normal release.
        if (!owner_req) begin
          state_d   = ST_DRAIN;
          grant_d   = '0;
          preempt_d = 1'b0;
        end else if (hold_hit && other_req) begin
          state_d   = ST_DRAIN;
          grant_d   = '0;
          preempt_d = 1'b1;
        end else begin
          wen_d = wr_q;
          ren_d = ~wr_q;
        end
      end

      ST_DRAIN: begin
        grant_d = '0;
        if (sdram_ready && (!wr_q || wr_fifo_empty)) begin
          state_d      = ST_IDLE;
          done_d       = owner_q ? 2'b10 : 2'b01;
          pre_d        = preempt_q ? done_d : 2'b00;
          last_owner_d = owner_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign p0_grant     = grant_q[0];
  assign p1_grant     = grant_q[1];
  assign p0_done      = done_q[0];
  assign p1_done      = done_q[1];
  assign p0_preempted = pre_q[0];
  assign p1_preempted = pre_q[1];
  assign write_en     = wen_q;
  assign read_en      = ren_q;
  assign address      = addr_q;
  assign busy         = (state_q != ST_IDLE);

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] p0_cnt_q, p1_cnt_q, pre_cnt_q;
  logic        grant_evt, preempt_evt;

  assign grant_evt   = (state_q == ST_IDLE) && (state_d == ST_ACTIVE);
  assign preempt_evt = (state_q == ST_DRAIN) && (state_d == ST_IDLE) && preempt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_cnt_q  <= '0;
      p1_cnt_q  <= '0;
      pre_cnt_q <= '0;
    end else begin
      if (grant_evt && !pick && (p0_cnt_q != 16'hFFFF)) p0_cnt_q <= p0_cnt_q + 16'd1;
      if (grant_evt &&  pick && (p1_cnt_q != 16'hFFFF)) p1_cnt_q <= p1_cnt_q + 16'd1;
      if (preempt_evt && (pre_cnt_q != 16'hFFFF))       pre_cnt_q <= pre_cnt_q + 16'd1;
    end
  end

  assign p0_grant_count = p0_cnt_q;
  assign p1_grant_count = p1_cnt_q;
  assign preempt_count  = pre_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Directed self-checking bench for sdram_arbiter (MAX_HOLD = 8).
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_write = 1'b0;
  logic [21:0] p0_address = '0;
  logic        p1_req = 1'b0, p1_write = 1'b0;
  logic [21:0] p1_address = '0;
  logic        sdram_ready = 1'b1, wr_fifo_empty = 1'b1;
  logic        p0_grant, p0_done, p0_preempted;
  logic        p1_grant, p1_done, p1_preempted;
  logic        write_en, read_en, busy;
  logic [21:0] address;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] p0_grant_count, p1_grant_count, preempt_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_write(p0_write), .p0_address(p0_address),
    .p0_grant(p0_grant), .p0_done(p0_done), .p0_preempted(p0_preempted),
    .p1_req(p1_req), .p1_write(p1_write), .p1_address(p1_address),
    .p1_grant(p1_grant), .p1_done(p1_done), .p1_preempted(p1_preempted),
    .sdram_ready(sdram_ready), .wr_fifo_empty(wr_fifo_empty),
    .write_en(write_en), .read_en(read_en), .address(address), .busy(busy)
`ifdef SDRAM_ARB_STATS_EN
    , .p0_grant_count(p0_grant_count), .p1_grant_count(p1_grant_count),
    .preempt_count(preempt_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(2);
    chk("rst_p0_grant", 32'(p0_grant), 32'd0);
    chk("rst_p1_grant", 32'(p1_grant), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_wen",      32'(write_en), 32'd0);
    chk("rst_ren",      32'(read_en),  32'd0);
    chk("rst_addr",     32'(address),  32'd0);
    chk("rst_done",     32'({p0_done, p1_done}), 32'd0);
    rst_n = 1'b1;

    // ---------------- single write, drain waits for FIFO ----------------
    p0_req = 1'b1; p0_write = 1'b1; p0_address = 22'h000100;
    tick;
    chk("w_grant",  32'(p0_grant), 32'd1);
    chk("w_p1g",    32'(p1_grant), 32'd0);
    chk("w_wen0",   32'(write_en), 32'd0);
    chk("w_addr",   32'(address),  32'h100);
    chk("w_busy",   32'(busy),     32'd1);
    tick;
    chk("w_wen1",   32'(write_en), 32'd1);
    chk("w_ren",    32'(read_en),  32'd0);
    wr_fifo_empty = 1'b0; p0_req = 1'b0;
    tick;
    chk("w_wen_off",  32'(write_en), 32'd0);
    chk("w_grant_off", 32'(p0_grant), 32'd0);
    chk("w_drain_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("w_done_held", 32'(p0_done), 32'd0);
    end
    wr_fifo_empty = 1'b1;
    tick;
    chk("w_done",    32'(p0_done),      32'd1);
    chk("w_pre",     32'(p0_preempted), 32'd0);
    chk("w_idle",    32'(busy),         32'd0);
    tick;
    chk("w_done_1cy", 32'(p0_done), 32'd0);

    // ---------------- tie after reset, round robin ----------------
    rst_n = 1'b0; tick; rst_n = 1'b1;
    p0_req = 1'b1; p1_req = 1'b1; p0_write = 1'b0; p1_write = 1'b0;
    p0_address = 22'h0000AA; p1_address = 22'h3ABCDE;
    tick;
    chk("t_p0g",  32'(p0_grant), 32'd1);
    chk("t_p1g",  32'(p1_grant), 32'd0);
    chk("t_addr", 32'(address),  32'h0000AA);
    tick;
    chk("t_ren",  32'(read_en),  32'd1);
    chk("t_wen",  32'(write_en), 32'd0);
    p0_req = 1'b0;
    tick;
    chk("t_drain_g", 32'({p0_grant, p1_grant}), 32'd0);
    chk("t_drain_r", 32'(read_en), 32'd0);
    tick;
    chk("t_done0", 32'(p0_done), 32'd1);
    tick;
    chk("t_p1g2",  32'(p1_grant), 32'd1);
    chk("t_p0g2",  32'(p0_grant), 32'd0);
    chk("t_addr2", 32'(address),  32'h3ABCDE);
    p0_req = 1'b1;
    tick;
    chk("t_ren1", 32'(read_en), 32'd1);
    p1_req = 1'b0;
    tick;
    p1_req = 1'b1;
    tick;
    chk("t_done1", 32'(p1_done),      32'd1);
    chk("t_pre1",  32'(p1_preempted), 32'd0);
    tick;
    chk("t_tie_p0", 32'(p0_grant), 32'd1);
    chk("t_tie_p1", 32'(p1_grant), 32'd0);

    // ---------------- preemption after MAX_HOLD active cycles ----------------
    for (int i = 0; i < MAX_HOLD; i++) begin
      chk("h_grant", 32'(p0_grant), 32'd1);
      chk("h_ren",   32'(read_en),  (i == 0) ? 32'd0 : 32'd1);
      tick;
    end
    chk("h_grant_drop", 32'(p0_grant), 32'd0);
    chk("h_ren_drop",   32'(read_en),  32'd0);
    chk("h_busy",       32'(busy),     32'd1);
    tick;
    chk("h_done", 32'(p0_done),      32'd1);
    chk("h_pre",  32'(p0_preempted), 32'd1);
    tick;
    chk("h_p1g", 32'(p1_grant), 32'd1);
    chk("h_p0g", 32'(p0_grant), 32'd0);
    p1_req = 1'b0;
    tick(2);
    chk("h_p1done", 32'(p1_done),      32'd1);
    chk("h_p1pre",  32'(p1_preempted), 32'd0);
    tick;
    chk("h_regrant", 32'(p0_grant), 32'd1);

    // ---------------- release in the expiry cycle ----------------
    p1_req = 1'b1;
    tick(MAX_HOLD - 1);
    chk("x_grant_last", 32'(p0_grant), 32'd1);
    p0_req = 1'b0;
    tick;
    chk("x_grant_drop", 32'(p0_grant), 32'd0);
    tick;
    chk("x_done", 32'(p0_done),      32'd1);
    chk("x_pre",  32'(p0_preempted), 32'd0);
    tick;
    chk("x_p1g",  32'(p1_grant), 32'd1);
    p1_req = 1'b0;
    tick(2);
    chk("x_p1done", 32'(p1_done), 32'd1);
`ifdef SDRAM_ARB_STATS_EN
    chk("s_p0cnt",  32'(p0_grant_count), 32'd3);
    chk("s_p1cnt",  32'(p1_grant_count), 32'd3);
    chk("s_precnt", 32'(preempt_count),  32'd1);
`endif

    // ---------------- controller not ready, then async reset ----------------
    sdram_ready = 1'b0; p0_req = 1'b1; p1_req = 1'b1; p0_address = 22'h155555;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("r_nogrant", 32'({p0_grant, p1_grant}), 32'd0);
      chk("r_idle",    32'(busy), 32'd0);
    end
    sdram_ready = 1'b1;
    tick;
    chk("r_p0g",  32'(p0_grant), 32'd1);
    chk("r_p1g",  32'(p1_grant), 32'd0);
    tick;
    chk("r_ren",  32'(read_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_ren",   32'(read_en),  32'd0);
    chk("a_grant", 32'({p0_grant, p1_grant}), 32'd0);
    chk("a_busy",  32'(busy),     32'd0);
`ifdef SDRAM_ARB_STATS_EN
    chk("a_p1cnt", 32'(p1_grant_count), 32'd0);
`endif
    tick;
    rst_n = 1'b1;
    tick;
    chk("a_first_p0", 32'(p0_grant), 32'd1);
    chk("a_first_p1", 32'(p1_grant), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
